maq_bcd_mod: RTL and testbench

Parametrised two-digit BCD modulo counter for the digital clock chain. It generalises the fixed 00–59 minute stage to any modulus from 2 to 99, so one block serves seconds (60), minutes (60) and hours (24).
- Adds down-counting with a borrow pulse, for countdown/timer mode.
- Adds synchronous BCD load with validity checking, and a carry-free adjust increment, for time setting.
- Cascaded through carry/borrow into the next stage's enable.

---
 rtl/maq_pkg.sv | 25 ++
 rtl/maq_bcd_mod_if.sv | 30 +++
 rtl/maq_bcd_digit.sv | 41 ++++
 rtl/maq_bcd_mod.sv | 152 +++++++++++++++
 tb/tb_maq_bcd_mod.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/maq_pkg.sv
// Shared types and constants for the digital clock BCD counter chain.
package maq_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAQ_MOD_SEC  = 60;
    localparam int MAQ_MOD_MIN  = 60;
    localparam int MAQ_MOD_HOUR = 24;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // What a counter stage does on the coming edge, after priority resolution.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_CLEAR,
        ACT_UP,
        ACT_DOWN
    } maq_action_t;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/maq_bcd_mod_if.sv
// Control and digit bus between a BCD modulo counter stage and its user.
interface maq_bcd_mod_if
    import maq_pkg::*;
#(
    parameter int MSD_W = 3
);
    logic             maqm_enable;
    logic             maqm_down;
    logic             maqm_load;
    bcd_digit_t       maqm_load_lsd;
    logic [MSD_W-1:0] maqm_load_msd;
    logic             maqm_set_inc;
    bcd_digit_t       maqm_lsd;
    logic [MSD_W-1:0] maqm_msd;
    logic             maqm_carry;
    logic             maqm_borrow;
    logic             maqm_load_err;

    modport master (
        output maqm_enable, maqm_down, maqm_load, maqm_load_lsd,
               maqm_load_msd, maqm_set_inc,
        input  maqm_lsd, maqm_msd, maqm_carry, maqm_borrow, maqm_load_err
    );

    modport slave (
        input  maqm_enable, maqm_down, maqm_load, maqm_load_lsd,
               maqm_load_msd, maqm_set_inc,
        output maqm_lsd, maqm_msd, maqm_carry, maqm_borrow, maqm_load_err
    );
endinterface

// File: rtl/maq_bcd_digit.sv
// One up/down BCD digit that wraps between 0 and TOP; load beats inc beats dec.
module maq_bcd_digit #(
    parameter int W   = 4,
    parameter int TOP = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] wrap_val,
    output logic [W-1:0] digit,
    output logic         at_top,
    output logic         at_zero
);
    localparam logic [W-1:0] TOP_V = W'(TOP);

    logic [W-1:0] digit_next;

    assign at_top  = (digit == TOP_V);
    assign at_zero = (digit == '0);

    always_comb begin
        digit_next = digit;
        if (load) begin
            digit_next = wrap_val;
        end else if (inc) begin
            digit_next = at_top ? '0 : digit + W'(1);
        end else if (dec) begin
            digit_next = at_zero ? TOP_V : digit - W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit <= '0;
        end else begin
            digit <= digit_next;
        end
    end
endmodule

// File: rtl/maq_bcd_mod.sv
// Two-digit BCD modulo counter (modulus 2..99) with up/down count, load and
// carry-free adjust; carry/borrow feed the next stage's enable.
module maq_bcd_mod
    import maq_pkg::*;
#(
    parameter int MODULUS = MAQ_MOD_MIN,
    parameter int MSD_W   = 3
) (
    input  logic         maqm_clock,
    input  logic         maqm_reset,
    maq_bcd_mod_if.slave bus
);
    localparam int TOP_MSD = (MODULUS - 1) / 10;
    localparam int TOP_LSD = (MODULUS - 1) % 10;
    localparam logic [MSD_W-1:0] TOP_MSD_V = MSD_W'(TOP_MSD);
    localparam bcd_digit_t       TOP_LSD_V = 4'(TOP_LSD);

    if (MODULUS < 2 || MODULUS > 99) begin : g_bad_modulus
        $error("maq_bcd_mod: MODULUS must lie in 2..99");
    end
    if ((1 << MSD_W) <= TOP_MSD) begin : g_bad_msd_w
        $error("maq_bcd_mod: MSD_W too narrow for MODULUS");
    end

    bcd_digit_t       lsd;
    logic [MSD_W-1:0] msd;
    logic             lsd_at_top, lsd_at_zero;
    logic             msd_at_top, msd_at_zero;
    logic             at_max, at_min, illegal, load_ok;
    logic             step_up, step_dn;
    maq_action_t      action;

    logic             lsd_ld, lsd_inc, lsd_dec;
    bcd_digit_t       lsd_val;
    logic             msd_ld, msd_inc, msd_dec;
    logic [MSD_W-1:0] msd_val;
    logic             load_err;

    assign at_max  = msd_at_top && (lsd == TOP_LSD_V);
    assign at_min  = msd_at_zero && lsd_at_zero;
    assign illegal = !bcd_valid(lsd) || (msd > TOP_MSD_V)
                     || (msd_at_top && (lsd > TOP_LSD_V));
    assign load_ok = bcd_valid(bus.maqm_load_lsd)
                     && ((bus.maqm_load_msd < TOP_MSD_V)
                         || ((bus.maqm_load_msd == TOP_MSD_V)
                             && (bus.maqm_load_lsd <= TOP_LSD_V)));

    // set_inc only counts when no load or enable tick claims the cycle.
    assign step_up = !bus.maqm_load
                     && ((bus.maqm_enable && !bus.maqm_down)
                         || (!bus.maqm_enable && bus.maqm_set_inc));
    assign step_dn = !bus.maqm_load && bus.maqm_enable && bus.maqm_down;

    always_comb begin
        action = ACT_HOLD;
        if (bus.maqm_load) begin
            action = load_ok ? ACT_LOAD : ACT_HOLD;
        end else if ((step_up || step_dn) && illegal) begin
            action = ACT_CLEAR;
        end else if (step_up) begin
            action = at_max ? ACT_CLEAR : ACT_UP;
        end else if (step_dn) begin
            action = ACT_DOWN;
        end
    end

    // Terminal wraps are done as loads so the digits only see plain BCD steps.
    always_comb begin
        lsd_ld  = 1'b0;
        lsd_val = '0;
        lsd_inc = 1'b0;
        lsd_dec = 1'b0;
        msd_ld  = 1'b0;
        msd_val = '0;
        msd_inc = 1'b0;
        msd_dec = 1'b0;
        case (action)
            ACT_LOAD: begin
                lsd_ld  = 1'b1;
                lsd_val = bus.maqm_load_lsd;
                msd_ld  = 1'b1;
                msd_val = bus.maqm_load_msd;
            end
            ACT_CLEAR: begin
                lsd_ld = 1'b1;
                msd_ld = 1'b1;
            end
            ACT_UP: begin
                lsd_inc = 1'b1;
                msd_inc = lsd_at_top;
            end
            ACT_DOWN: begin
                if (at_min) begin
                    lsd_ld  = 1'b1;
                    lsd_val = TOP_LSD_V;
                    msd_ld  = 1'b1;
                    msd_val = TOP_MSD_V;
                end else begin
                    lsd_dec = 1'b1;
                    msd_dec = lsd_at_zero;
                end
            end
            default: ;
        endcase
    end

    maq_bcd_digit #(
        .W   (4),
        .TOP (9)
    ) u_lsd (
        .clock    (maqm_clock),
        .reset    (maqm_reset),
        .inc      (lsd_inc),
        .dec      (lsd_dec),
        .load     (lsd_ld),
        .wrap_val (lsd_val),
        .digit    (lsd),
        .at_top   (lsd_at_top),
        .at_zero  (lsd_at_zero)
    );

    maq_bcd_digit #(
        .W   (MSD_W),
        .TOP (TOP_MSD)
    ) u_msd (
        .clock    (maqm_clock),
        .reset    (maqm_reset),
        .inc      (msd_inc),
        .dec      (msd_dec),
        .load     (msd_ld),
        .wrap_val (msd_val),
        .digit    (msd),
        .at_top   (msd_at_top),
        .at_zero  (msd_at_zero)
    );

    always_ff @(posedge maqm_clock or posedge maqm_reset) begin
        if (maqm_reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= bus.maqm_load && !load_ok;
        end
    end

    assign bus.maqm_lsd      = lsd;
    assign bus.maqm_msd      = msd;
    assign bus.maqm_load_err = load_err;
    assign bus.maqm_carry    = bus.maqm_enable && !bus.maqm_down && !bus.maqm_load
                               && !maqm_reset && at_max;
    assign bus.maqm_borrow   = bus.maqm_enable && bus.maqm_down && !bus.maqm_load
                               && !maqm_reset && at_min;
endmodule

// File: tb/tb_maq_bcd_mod.sv
// Directed bench for maq_bcd_mod: a modulus-60 stage and a modulus-24 stage.
module tb_maq_bcd_mod;
    import maq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic seen_carry;
    logic seen_borrow;

    maq_bcd_mod_if #(.MSD_W(3)) bus60 ();
    maq_bcd_mod_if #(.MSD_W(2)) bus24 ();

    maq_bcd_mod #(.MODULUS(MAQ_MOD_MIN), .MSD_W(3)) dut60 (
        .maqm_clock (clock),
        .maqm_reset (reset),
        .bus        (bus60.slave)
    );

    maq_bcd_mod #(.MODULUS(MAQ_MOD_HOUR), .MSD_W(2)) dut24 (
        .maqm_clock (clock),
        .maqm_reset (reset),
        .bus        (bus24.slave)
    );

    always #5 clock = ~clock;

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int state60();
        return int'(bus60.maqm_msd) * 16 + int'(bus60.maqm_lsd);
    endfunction

    function automatic int state24();
        return int'(bus24.maqm_msd) * 16 + int'(bus24.maqm_lsd);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        bus60.maqm_enable = 1'b0; bus60.maqm_down = 1'b0; bus60.maqm_load = 1'b0;
        bus60.maqm_load_lsd = '0; bus60.maqm_load_msd = '0; bus60.maqm_set_inc = 1'b0;
        bus24.maqm_enable = 1'b0; bus24.maqm_down = 1'b0; bus24.maqm_load = 1'b0;
        bus24.maqm_load_lsd = '0; bus24.maqm_load_msd = '0; bus24.maqm_set_inc = 1'b0;
    endtask

    // One clock of stimulus on one stage; carry/borrow are captured before the edge.
    task automatic applyStimulus(input bit sel24, input logic en, input logic dn,
                                 input logic ld, input int l_msd, input int l_lsd,
                                 input logic inc);
        @(negedge clock);
        if (sel24) begin
            bus24.maqm_enable = en; bus24.maqm_down = dn; bus24.maqm_load = ld;
            bus24.maqm_load_msd = 2'(l_msd); bus24.maqm_load_lsd = 4'(l_lsd);
            bus24.maqm_set_inc = inc;
        end else begin
            bus60.maqm_enable = en; bus60.maqm_down = dn; bus60.maqm_load = ld;
            bus60.maqm_load_msd = 3'(l_msd); bus60.maqm_load_lsd = 4'(l_lsd);
            bus60.maqm_set_inc = inc;
        end
        #1;
        seen_carry  = sel24 ? bus24.maqm_carry  : bus60.maqm_carry;
        seen_borrow = sel24 ? bus24.maqm_borrow : bus60.maqm_borrow;
        @(posedge clock);
        #1;
        clearInputs();
    endtask

    initial begin
        clearInputs();
        bus60.maqm_enable = 1'b1;
        #1 reset = 1'b1;
        #3;
        checkOutput("rst_state60", state60(), 0);
        checkOutput("rst_state24", state24(), 0);
        checkOutput("rst_carry", bus60.maqm_carry, 0);
        checkOutput("rst_err", bus60.maqm_load_err, 0);
        @(negedge clock);
        reset = 1'b0;
        clearInputs();

        for (int i = 0; i < 60; i++) begin
            checkOutput("up60_state", state60(), bcd(i));
            applyStimulus(0, 1, 0, 0, 0, 0, 0);
            checkOutput("up60_carry", seen_carry, (i == 59) ? 1 : 0);
        end
        checkOutput("up60_wrap", state60(), 0);

        applyStimulus(0, 0, 0, 1, 6, 0, 0);
        checkOutput("ld60_rej_state", state60(), 0);
        checkOutput("ld60_rej_err", bus60.maqm_load_err, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ld_err_pulse", bus60.maqm_load_err, 0);
        applyStimulus(0, 0, 0, 1, 0, 12, 0);
        checkOutput("ld_lsd12_state", state60(), 0);
        checkOutput("ld_lsd12_err", bus60.maqm_load_err, 1);
        applyStimulus(0, 0, 0, 1, 4, 5, 0);
        checkOutput("ld45_state", state60(), bcd(45));
        checkOutput("ld45_err", bus60.maqm_load_err, 0);

        applyStimulus(0, 0, 0, 1, 5, 9, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("setinc_carry", seen_carry, 0);
        checkOutput("setinc_wrap", state60(), 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1);
        checkOutput("en_setinc", state60(), bcd(1));

        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dn_borrow0", seen_borrow, 0);
        checkOutput("dn_state00", state60(), 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dn_borrow1", seen_borrow, 1);
        checkOutput("dn_wrap59", state60(), bcd(59));
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dn_58", state60(), bcd(58));
        applyStimulus(0, 1, 1, 1, 5, 0, 0);
        checkOutput("dn_ld_borrow", seen_borrow, 0);
        checkOutput("dn_ld_state", state60(), bcd(50));
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        checkOutput("dn_49", state60(), bcd(49));

        applyStimulus(0, 0, 0, 1, 5, 9, 0);
        applyStimulus(0, 1, 0, 1, 1, 2, 0);
        checkOutput("ld_en_carry", seen_carry, 0);
        checkOutput("ld_en_state", state60(), bcd(12));

        // Reset arriving mid-cycle while a wrapping tick is pending.
        applyStimulus(0, 0, 0, 1, 5, 9, 0);
        @(negedge clock);
        bus60.maqm_enable = 1'b1;
        #1;
        checkOutput("pre_rst_carry", bus60.maqm_carry, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst59_carry", bus60.maqm_carry, 0);
        checkOutput("rst59_state", state60(), 0);
        @(negedge clock);
        reset = 1'b0;
        clearInputs();

        applyStimulus(0, 0, 0, 1, 3, 7, 0);
        checkOutput("ld37_state", state60(), bcd(37));
        applyStimulus(0, 0, 0, 1, 6, 0, 0);
        checkOutput("ld37_rej_err", bus60.maqm_load_err, 1);
        checkOutput("ld37_rej_state", state60(), bcd(37));
        @(negedge clock);
        bus60.maqm_enable = 1'b1;
        #2 reset = 1'b1;
        #1;
        checkOutput("rst37_state", state60(), 0);
        checkOutput("rst37_carry", bus60.maqm_carry, 0);
        checkOutput("rst37_borrow", bus60.maqm_borrow, 0);
        checkOutput("rst37_err", bus60.maqm_load_err, 0);
        @(negedge clock);
        reset = 1'b0;
        clearInputs();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_hold", state60(), 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("post_rst_count", state60(), bcd(1));

        applyStimulus(1, 0, 0, 1, 2, 3, 0);
        checkOutput("h_ld23", state24(), bcd(23));
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("h_carry", seen_carry, 1);
        checkOutput("h_wrap00", state24(), 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("h_borrow", seen_borrow, 1);
        checkOutput("h_wrap23", state24(), bcd(23));
        applyStimulus(1, 0, 0, 1, 0, 9, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("h_09_10", state24(), bcd(10));
        checkOutput("h_09_carry", seen_carry, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("h_11", state24(), bcd(11));
        applyStimulus(1, 1, 1, 1, 1, 9, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("h_19_20", state24(), bcd(20));
        applyStimulus(1, 1, 1, 0, 0, 0, 0);
        checkOutput("h_20_19", state24(), bcd(19));
        applyStimulus(1, 0, 0, 1, 2, 4, 0);
        checkOutput("h_ld24_err", bus24.maqm_load_err, 1);
        checkOutput("h_ld24_state", state24(), bcd(19));
        applyStimulus(1, 0, 0, 1, 2, 3, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("h_setinc_carry", seen_carry, 0);
        checkOutput("h_setinc_wrap", state24(), 0);
        checkOutput("h_iso60", state60(), bcd(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
